simon_key_expander: RTL and testbench
=====================================

# simon_key_expander

Generates the 32 SIMON 32/64 round keys from a 64-bit master key and streams them to the round datapath. It sits between the SPI control FSM, which supplies the key and a start pulse, and the round core, which consumes one 16-bit round key per round. The stream runs in forward order for encryption and reverse order for decryption. All 32 keys are expanded into a local buffer first, so the consumer can stall freely.

## Interface
Parameters:
- `ROUNDS`, 32, number of round keys generated and streamed
- `WORD_W`, 16, round-key word width

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse: latch `key` and `mode`, begin expansion
- `key`  in  64  master key; k0=`key[15:0]`, k1=`key[31:16]`, k2=`key[47:32]`, k3=`key[63:48]`
- `mode`  in  1  0 = stream k0..k31, 1 = stream k31..k0
- `busy`  out  1  high while expanding or streaming
- `rk_valid`  out  1  `rk_data` holds a valid round key
- `rk_ready`  in  1  consumer accepts `rk_data` this cycle
- `rk_data`  out  16  current round key
- `rk_index`  out  5  round index of `rk_data`
- `done`  out  1  all 32 keys transferred; held until next `start` or `rst`

## Operation
- States: IDLE, EXPAND, STREAM, DONE.
- Reset forces IDLE and drives `busy`=0, `rk_valid`=0, `rk_data`=0, `rk_index`=0, `done`=0. Buffer contents after reset are don't-care.
- IDLE or DONE, with `start`=1:
  - write k0..k3 into buffer[0..3]
  - latch `mode`
  - set the generation counter `i` to 4
  - clear `done`, go to EXPAND
- EXPAND: one key per cycle, buffer[i] = C ^ z0[i-4] ^ k[i-4] ^ t ^ ror(t,1), where t = ror(k[i-1],3) ^ k[i-3].
  - C = 16'hFFFC.
  - z0 is the 62-bit SIMON z0 sequence, indexed from its MSB.
  - `i` increments. After writing buffer[31], go to STREAM.
  - Set the stream pointer to 0 (`mode`=0) or 31 (`mode`=1).
- STREAM:
  - `rk_valid`=1, `rk_index`=pointer, `rk_data`=buffer[pointer].
  - On `rk_valid`&`rk_ready`, the pointer steps +1 (forward) or -1 (reverse).
  - The 32nd transfer goes to DONE with `rk_valid`=0 and `done`=1.
- `start` in EXPAND or STREAM aborts the run and restarts from the new key and mode, using the same actions as from IDLE. `done` stays 0.
- `rst` asserted together with `start`: reset wins.
- All arithmetic is 16-bit XOR and rotate; there are no carries. Counters are 5-bit and never wrap, because the state changes at 31 / 0.

## Timing
- `start` sampled at edge E0. Keys k4..k31 are written at edges E1..E28.
- `rk_valid` rises after E28: first key available 28 cycles after `start`.
- With `rk_ready` held high, one transfer per cycle. The 32nd transfer occurs at E60, and `done` is high after E60.
- `rk_data` and `rk_index` are stable while `rk_valid`=1 and `rk_ready`=0.
- `rk_valid` never drops without a transfer, except on `rst` or `start`.
- `busy` is high from the cycle after E0 until the DONE transition.

## Structure
- Package `simon_pkg` holds:
  - `SIMON_C` (16'hFFFC)
  - `SIMON_Z0` (62-bit constant)
  - `SIMON_WORD_W`, `SIMON_ROUNDS`
  - the state enum
- Sub-module `simon_ks_next`: purely combinational. Takes k[i-4], k[i-3], k[i-1] and the z bit, and returns k[i]. It is reusable by the round core's on-the-fly variant.
- Buffer: 32×16 flops in the top module. No SRAM.

## Test plan
- Standard vector, key 64'h1918_1110_0908_0100, `mode`=0, `rk_ready`=1:
  - stream indices 0..31 with k0..k3 = 0100, 0908, 1110, 1918
  - k4..k31 match the software model
  - `done` rises 60 cycles after `start`
- Same key, `mode`=1: first key out has `rk_index`=31 and equals model k31. Last key out has `rk_index`=0 and data 16'h0100.
- Random `rk_ready` stalls (~50%): `rk_data` and `rk_index` are held stable while stalled. Exactly 32 transfers occur, with no duplicates or skips.
- `start` at stream transfer 10 with new key 64'h0: run restarts. Output resumes 28 cycles later with index 0 and data 16'h0000. `done` stays 0 until the new run completes.
- `rst` mid-EXPAND and mid-STREAM: all outputs 0 on the next cycle. No `rk_valid` until the next `start`.
- `start` and `rst` in the same cycle: remains IDLE, `busy`=0.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared constants, state type and helpers for the SIMON 32/64 key schedule.
package simon_pkg;

  localparam int SIMON_WORD_W = 16;
  localparam int SIMON_ROUNDS = 32;

  // Round constant: ~k[i-4] ^ 3 is folded into k[i-4] ^ SIMON_C.
  localparam logic [15:0] SIMON_C = 16'hFFFC;

  // z0 sequence, bit 61 is z0[0].
  localparam logic [61:0] SIMON_Z0 = 62'h3E89_5873_7D12_B0E6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } simon_state_e;

  // z0[j], indexed from the MSB of the packed constant.
  function automatic logic simon_z0_bit(input logic [5:0] j);
    logic [5:0] w_pos;
    w_pos = 6'd61 - j;
    return SIMON_Z0[w_pos];
  endfunction

endpackage

// File: rtl/simon_ks_next.sv
// One SIMON 32/64 key-schedule step: k[i] from k[i-4], k[i-3], k[i-1], z bit.
// Purely combinational so an on-the-fly round core can reuse it.
module simon_ks_next
  import simon_pkg::*;
#(
  parameter int WORD_W = SIMON_WORD_W
) (
  input  logic [WORD_W-1:0] i_km4,
  input  logic [WORD_W-1:0] i_km3,
  input  logic [WORD_W-1:0] i_km1,
  input  logic              i_z,
  output logic [WORD_W-1:0] o_k
);

  logic [WORD_W-1:0] w_t;
  logic [WORD_W-1:0] w_t_r1;
  logic [WORD_W-1:0] w_z;

  // t = ror(k[i-1],3) ^ k[i-3]; k[i] = C ^ z ^ k[i-4] ^ t ^ ror(t,1)
  always_comb begin
    w_t    = {i_km1[2:0], i_km1[WORD_W-1:3]} ^ i_km3;
    w_t_r1 = {w_t[0], w_t[WORD_W-1:1]};
    w_z    = {{(WORD_W-1){1'b0}}, i_z};
    o_k    = WORD_W'(SIMON_C) ^ w_z ^ i_km4 ^ w_t ^ w_t_r1;
  end

endmodule

// File: rtl/simon_key_expander.sv
// Expands a 64-bit master key into 32 round keys held in a flop buffer,
// then streams them forward (encrypt) or reverse (decrypt) with valid/ready.
module simon_key_expander
  import simon_pkg::*;
#(
  parameter int ROUNDS = SIMON_ROUNDS,
  parameter int WORD_W = SIMON_WORD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*WORD_W-1:0] key,
  input  logic                mode,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [WORD_W-1:0]   rk_data,
  output logic [4:0]          rk_index,
  output logic                done
);

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  simon_state_e      r_state;
  simon_state_e      w_next;
  logic              r_mode;
  logic [4:0]        r_i;
  logic [4:0]        r_ptr;
  logic [WORD_W-1:0] r_buf [ROUNDS];

  logic [WORD_W-1:0] w_knext;
  logic              w_zbit;
  logic              w_last_gen;
  logic              w_xfer;
  logic              w_last_xfer;

  assign w_zbit      = simon_z0_bit({1'b0, r_i - 5'd4});
  assign w_last_gen  = (r_i == LAST);
  assign w_xfer      = (r_state == ST_STREAM) && rk_ready;
  // Stream ends at the far end of the buffer for the chosen direction.
  assign w_last_xfer = w_xfer && (r_mode ? (r_ptr == 5'd0) : (r_ptr == LAST));

  simon_ks_next #(.WORD_W(WORD_W)) u_ks_next (
    .i_km4 (r_buf[r_i - 5'd4]),
    .i_km3 (r_buf[r_i - 5'd3]),
    .i_km1 (r_buf[r_i - 5'd1]),
    .i_z   (w_zbit),
    .o_k   (w_knext)
  );

  // Next-state: start always (re)launches expansion from any state.
  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = ST_EXPAND;
    end else begin
      case (r_state)
        ST_EXPAND: if (w_last_gen)  w_next = ST_STREAM;
        ST_STREAM: if (w_last_xfer) w_next = ST_DONE;
        default:   w_next = r_state;
      endcase
    end
  end

  // State register; reset wins over a coincident start.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Generation counter, stream pointer and direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 1'b0;
      r_i    <= 5'd0;
      r_ptr  <= 5'd0;
    end else if (start) begin
      r_mode <= mode;
      r_i    <= 5'd4;
    end else begin
      case (r_state)
        ST_EXPAND: begin
          r_i <= r_i + 5'd1;
          if (w_last_gen) r_ptr <= r_mode ? LAST : 5'd0;
        end
        ST_STREAM: begin
          if (w_xfer && !w_last_xfer)
            r_ptr <= r_mode ? (r_ptr - 5'd1) : (r_ptr + 5'd1);
        end
        default: ;
      endcase
    end
  end

  // Key buffer; contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (start) begin
        for (int w = 0; w < 4; w++)
          r_buf[w] <= key[w*WORD_W +: WORD_W];
      end else if (r_state == ST_EXPAND) begin
        r_buf[r_i] <= w_knext;
      end
    end
  end

  // Outputs decode from state; data/index are forced to 0 outside STREAM.
  always_comb begin
    busy     = (r_state == ST_EXPAND) || (r_state == ST_STREAM);
    rk_valid = (r_state == ST_STREAM);
    done     = (r_state == ST_DONE);
    rk_data  = rk_valid ? r_buf[r_ptr] : '0;
    rk_index = rk_valid ? r_ptr : 5'd0;
  end

endmodule

// File: tb/tb_simon_key_expander.sv
// Self-checking bench for simon_key_expander against a software key schedule.
module tb_simon_key_expander;

  logic        clk = 1'b0;
  logic        rst, start, mode, rk_ready;
  logic [63:0] key;
  logic        busy, rk_valid, done;
  logic [15:0] rk_data;
  logic [4:0]  rk_index;

  int errors = 0;
  int checks = 0;

  logic [15:0] mk [32];
  logic [15:0] cap_dat [32];
  logic [4:0]  cap_idx [32];

  always #5 clk = ~clk;

  simon_key_expander dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .mode(mode),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_index(rk_index), .done(done)
  );

  function automatic logic [15:0] ror16(input logic [15:0] x, input int n);
    return (x >> n) | (x << (16 - n));
  endfunction

  function automatic logic [15:0] rol16(input logic [15:0] x, input int n);
    return (x << n) | (x >> (16 - n));
  endfunction

  // Reference SIMON 32/64 key schedule (reference-implementation form).
  task automatic compute_model(input logic [63:0] k);
    logic [61:0] zseq;
    logic [15:0] tmp;
    zseq = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int j = 0; j < 4; j++) mk[j] = k[16*j +: 16];
    for (int j = 4; j < 32; j++) begin
      tmp = ror16(mk[j-1], 3) ^ mk[j-3];
      tmp = tmp ^ ror16(tmp, 1);
      mk[j] = ~mk[j-4] ^ tmp ^ {15'd0, zseq[61-(j-4)]} ^ 16'd3;
    end
  endtask

  task automatic pulse_start(input logic [63:0] k, input logic m);
    key = k; mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Launches a run and monitors it to DONE, capturing transfers in order.
  task automatic stream_run(input logic [63:0] k, input logic m, input int pct,
                            output int first_cyc, output int done_cyc,
                            output int nx, output int stab_bad, output int busy_bad);
    int cyc;
    logic pv;
    logic [15:0] pdat;
    logic [4:0]  pidx;
    pulse_start(k, m);
    rk_ready = 1'b0;
    cyc = 0; first_cyc = -1; done_cyc = -1; nx = 0; stab_bad = 0; busy_bad = 0;
    pv = 1'b0; pdat = '0; pidx = '0;
    while (cyc < 400 && done_cyc < 0) begin
      @(posedge clk); #1; cyc++;
      if (pv && !(rk_valid && rk_index == pidx && rk_data == pdat)) stab_bad++;
      if (rk_valid && first_cyc < 0) first_cyc = cyc;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (!done && !busy) busy_bad++;
      rk_ready = ($urandom_range(99) < pct);
      if (rk_valid && rk_ready) begin
        if (nx < 32) begin cap_dat[nx] = rk_data; cap_idx[nx] = rk_index; end
        nx++;
      end
      pv = rk_valid && !rk_ready; pdat = rk_data; pidx = rk_index;
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key = '0; mode = 1'b0; rk_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rk_valid); end
    checks++; if (rk_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h expected 0000", rk_data); end
    checks++; if (rk_index !== 5'd0) begin errors++; $display("FAIL reset_index: got %0d expected 0", rk_index); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    int fc, dc, nx, sb, bb;
    logic [15:0] x, y, t;
    compute_model(64'h1918_1110_0908_0100);
    stream_run(64'h1918_1110_0908_0100, 1'b0, 100, fc, dc, nx, sb, bb);
    checks++; if (fc !== 28) begin errors++; $display("FAIL fwd_first_latency: got %0d expected 28", fc); end
    checks++; if (dc !== 60) begin errors++; $display("FAIL fwd_done_latency: got %0d expected 60", dc); end
    checks++; if (nx !== 32) begin errors++; $display("FAIL fwd_xfer_count: got %0d expected 32", nx); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL fwd_busy: got %0d low cycles expected 0", bb); end
    for (int n = 0; n < 32 && n < nx; n++) begin
      checks++;
      if (cap_idx[n] !== 5'(n) || cap_dat[n] !== mk[n]) begin
        errors++;
        $display("FAIL fwd_key[%0d]: got idx %0d data %h expected idx %0d data %h", n, cap_idx[n], cap_dat[n], n, mk[n]);
      end
    end
    // Streamed keys must encrypt the published vector correctly.
    x = 16'h6565; y = 16'h6877;
    for (int n = 0; n < 32; n++) begin
      t = x;
      x = y ^ (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2) ^ cap_dat[n];
      y = t;
    end
    checks++; if ({x, y} !== 32'hc69b_e9bb) begin errors++; $display("FAIL fwd_cipher: got %h expected c69be9bb", {x, y}); end
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL fwd_done_state: got busy %b done %b expected 0 1", busy, done); end
    repeat (3) @(posedge clk); #1;
    checks++; if (done !== 1'b1 || rk_valid !== 1'b0) begin errors++; $display("FAIL fwd_done_hold: got done %b valid %b expected 1 0", done, rk_valid); end
  endtask

  task automatic test_reverse();
    int fc, dc, nx, sb, bb;
    compute_model(64'h1918_1110_0908_0100);
    stream_run(64'h1918_1110_0908_0100, 1'b1, 100, fc, dc, nx, sb, bb);
    checks++; if (nx !== 32) begin errors++; $display("FAIL rev_xfer_count: got %0d expected 32", nx); end
    checks++; if (cap_idx[0] !== 5'd31 || cap_dat[0] !== mk[31]) begin errors++; $display("FAIL rev_first: got idx %0d data %h expected idx 31 data %h", cap_idx[0], cap_dat[0], mk[31]); end
    checks++; if (cap_idx[31] !== 5'd0 || cap_dat[31] !== 16'h0100) begin errors++; $display("FAIL rev_last: got idx %0d data %h expected idx 0 data 0100", cap_idx[31], cap_dat[31]); end
    checks++; if (dc !== 60) begin errors++; $display("FAIL rev_done_latency: got %0d expected 60", dc); end
  endtask

  task automatic test_stall();
    int fc, dc, nx, sb, bb;
    logic [63:0] k;
    logic m;
    for (int r = 0; r < 4; r++) begin
      k = {$urandom, $urandom};
      m = 1'($urandom_range(1));
      compute_model(k);
      stream_run(k, m, 50, fc, dc, nx, sb, bb);
      checks++; if (nx !== 32) begin errors++; $display("FAIL stall_xfer_count[%0d]: got %0d expected 32", r, nx); end
      checks++; if (sb !== 0) begin errors++; $display("FAIL stall_stability[%0d]: got %0d changes expected 0", r, sb); end
      checks++; if (fc !== 28) begin errors++; $display("FAIL stall_first_latency[%0d]: got %0d expected 28", r, fc); end
      for (int n = 0; n < 32 && n < nx; n++) begin
        checks++;
        if (cap_idx[n] !== 5'(m ? 31 - n : n) || cap_dat[n] !== mk[m ? 31 - n : n]) begin
          errors++;
          $display("FAIL stall_key[%0d][%0d]: got idx %0d data %h expected idx %0d data %h",
                   r, n, cap_idx[n], cap_dat[n], m ? 31 - n : n, mk[m ? 31 - n : n]);
        end
      end
    end
  endtask

  task automatic test_restart();
    int fc, dc, nx, sb, bb, cnt, cyc, bad_done;
    pulse_start(64'h0123_4567_89AB_CDEF, 1'b0);
    rk_ready = 1'b1; cnt = 0; cyc = 0; bad_done = 0;
    while (cnt < 10 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (done) bad_done++;
      if (rk_valid && rk_ready) cnt++;
    end
    checks++; if (cnt !== 10) begin errors++; $display("FAIL restart_reach10: got %0d expected 10", cnt); end
    stream_run(64'h0, 1'b0, 100, fc, dc, nx, sb, bb);
    checks++; if (fc !== 28) begin errors++; $display("FAIL restart_latency: got %0d expected 28", fc); end
    checks++; if (cap_idx[0] !== 5'd0 || cap_dat[0] !== 16'h0000) begin errors++; $display("FAIL restart_first: got idx %0d data %h expected idx 0 data 0000", cap_idx[0], cap_dat[0]); end
    checks++; if (dc !== 60 || bad_done !== 0) begin errors++; $display("FAIL restart_done: got done at %0d early %0d expected 60 0", dc, bad_done); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL restart_busy: got %0d low cycles expected 0", bb); end
  endtask

  task automatic test_rst_mid();
    int vcnt;
    for (int s = 0; s < 2; s++) begin
      pulse_start({$urandom, $urandom}, 1'b0);
      rk_ready = 1'b1;
      repeat (s ? 39 : 9) @(posedge clk); #1;
      checks++;
      if (busy !== 1'b1 || rk_valid !== 1'(s)) begin
        errors++; $display("FAIL rst_mid_pre[%0d]: got busy %b valid %b expected 1 %0d", s, busy, rk_valid, s);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({busy, rk_valid, rk_data, rk_index, done} !== 24'h0) begin
        errors++; $display("FAIL rst_mid_outputs[%0d]: got %h expected 000000", s, {busy, rk_valid, rk_data, rk_index, done});
      end
      vcnt = 0;
      repeat (40) begin @(posedge clk); #1; if (rk_valid || busy) vcnt++; end
      checks++; if (vcnt !== 0) begin errors++; $display("FAIL rst_mid_quiet[%0d]: got %0d active cycles expected 0", s, vcnt); end
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_start_rst();
    int bcnt;
    rst = 1'b1; start = 1'b1; key = {$urandom, $urandom}; mode = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0 || rk_valid !== 1'b0) begin errors++; $display("FAIL start_rst_idle: got busy %b valid %b expected 0 0", busy, rk_valid); end
    bcnt = 0;
    repeat (35) begin @(posedge clk); #1; if (busy || rk_valid || done) bcnt++; end
    checks++; if (bcnt !== 0) begin errors++; $display("FAIL start_rst_stay: got %0d active cycles expected 0", bcnt); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_stall();
    test_restart();
    test_rst_mid();
    test_start_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
